// File: rtl/noc_local_injector.sv
// Local-port wormhole injector: turns a descriptor plus a payload beat stream into
// head/body/tail flits on one round-robin-selected virtual channel.
module noc_local_injector #(
    parameter int FLIT_W   = 64,
    parameter int CHANNELS = 2,
    parameter int ID_X_W   = 4,
    parameter int ID_Y_W   = 4,
    parameter int MAX_LEN  = 16,
    parameter int LEN_W    = $clog2(MAX_LEN + 1)
) (
    input  logic                noc_clk,
    input  logic                noc_rst,
    input  logic [ID_X_W-1:0]   id_x,
    input  logic [ID_Y_W-1:0]   id_y,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ID_X_W-1:0]   req_dest_x,
    input  logic [ID_Y_W-1:0]   req_dest_y,
    input  logic [LEN_W-1:0]    req_len,
    input  logic                pld_valid,
    output logic                pld_ready,
    input  logic [FLIT_W-3:0]   pld_data,
    output logic [CHANNELS-1:0] tx_valid,
    output logic [FLIT_W-1:0]   tx_flit,
    input  logic [CHANNELS-1:0] tx_ready,
    input  logic [CHANNELS-1:0] tx_vc_ready,
    output logic                busy,
    output logic                len_err,
    output logic [15:0]         pkt_count
);
    localparam int VC_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PLD_W = FLIT_W - 2;

    localparam logic [1:0] FT_BODY = 2'b00;
    localparam logic [1:0] FT_HEAD = 2'b01;
    localparam logic [1:0] FT_TAIL = 2'b10;
    localparam logic [1:0] FT_HT   = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_ARB, S_HEAD, S_BODY} state_t;

    state_t             state_q;
    logic [VC_W-1:0]    rr_q, vc_q;
    logic [ID_X_W-1:0]  dest_x_q, src_x_q;
    logic [ID_Y_W-1:0]  dest_y_q, src_y_q;
    logic [LEN_W-1:0]   len_q, rem_q;
    logic               req_ready_q, len_err_q;
    logic [15:0]        pkt_count_q;

    logic               arb_hit;
    logic [VC_W-1:0]    arb_vc, rr_d;
    logic [LEN_W-1:0]   len_d;
    logic               head_hs, body_hs;
    logic [PLD_W-1:0]   head_pld;
    int                 idx;

    // Round-robin scan of tx_vc_ready starting at rr_q, wrapping at CHANNELS.
    always_comb begin
        arb_hit = 1'b0;
        arb_vc  = '0;
        idx     = 0;
        for (int i = 0; i < CHANNELS; i++) begin
            idx = (int'(rr_q) + i) % CHANNELS;
            if (!arb_hit && tx_vc_ready[idx]) begin
                arb_hit = 1'b1;
                arb_vc  = VC_W'(idx);
            end
        end
        rr_d = (int'(arb_vc) == CHANNELS - 1) ? '0 : arb_vc + VC_W'(1);
    end

    assign len_d    = (req_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : req_len;
    assign head_hs  = (state_q == S_HEAD) && tx_ready[vc_q];
    assign body_hs  = (state_q == S_BODY) && pld_valid && tx_ready[vc_q];
    assign head_pld = PLD_W'({len_q, src_y_q, src_x_q, dest_y_q, dest_x_q});

    always_comb begin
        tx_valid  = '0;
        tx_flit   = '0;
        pld_ready = 1'b0;
        case (state_q)
            S_HEAD: begin
                tx_valid[vc_q] = 1'b1;
                tx_flit        = {(len_q == '0) ? FT_HT : FT_HEAD, head_pld};
            end
            S_BODY: begin
                tx_valid[vc_q] = pld_valid;
                pld_ready      = tx_ready[vc_q];
                tx_flit        = {(rem_q == LEN_W'(1)) ? FT_TAIL : FT_BODY, pld_data};
            end
            default: ;
        endcase
    end

    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            state_q     <= S_IDLE;
            rr_q        <= '0;
            vc_q        <= '0;
            dest_x_q    <= '0;
            dest_y_q    <= '0;
            src_x_q     <= '0;
            src_y_q     <= '0;
            len_q       <= '0;
            rem_q       <= '0;
            req_ready_q <= 1'b0;
            len_err_q   <= 1'b0;
            pkt_count_q <= '0;
        end else begin
            len_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // req_ready is registered so it stays low through reset.
                    if (req_valid && req_ready_q) begin
                        dest_x_q    <= req_dest_x;
                        dest_y_q    <= req_dest_y;
                        src_x_q     <= id_x;
                        src_y_q     <= id_y;
                        len_q       <= len_d;
                        len_err_q   <= (req_len > LEN_W'(MAX_LEN));
                        req_ready_q <= 1'b0;
                        state_q     <= S_ARB;
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                S_ARB: begin
                    if (arb_hit) begin
                        vc_q    <= arb_vc;
                        rr_q    <= rr_d;
                        state_q <= S_HEAD;
                    end
                end
                S_HEAD: begin
                    if (head_hs) begin
                        if (len_q == '0) begin
                            pkt_count_q <= pkt_count_q + 16'd1;
                            req_ready_q <= 1'b1;
                            state_q     <= S_IDLE;
                        end else begin
                            rem_q   <= len_q;
                            state_q <= S_BODY;
                        end
                    end
                end
                S_BODY: begin
                    if (body_hs) begin
                        rem_q <= rem_q - LEN_W'(1);
                        if (rem_q == LEN_W'(1)) begin
                            pkt_count_q <= pkt_count_q + 16'd1;
                            req_ready_q <= 1'b1;
                            state_q     <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign busy      = (state_q != S_IDLE);
    assign len_err   = len_err_q;
    assign pkt_count = pkt_count_q;

endmodule

// File: doc/noc_local_injector.md
# noc_local_injector

Local-port packet injector for the mesh NoC. It sits between a tile's traffic source and the router's local receiver port. It accepts a packet descriptor and a payload beat stream, then emits a wormhole packet: one head flit, then body flits, with the last one marked tail. The packet goes out on one virtual channel, chosen round-robin among the VCs the router reports as ready.

## Interface
Parameters:
- FLIT_W, 64, flit width; bits [FLIT_W-1:FLIT_W-2] are the flit type, the rest is payload.
- CHANNELS, 2, number of virtual channels.
- ID_X_W, 4, X coordinate width.
- ID_Y_W, 4, Y coordinate width.
- MAX_LEN, 16, maximum body beats per packet.
- LEN_W, $clog2(MAX_LEN+1), length field width.

Ports:
- noc_clk  in  1  clock; the only clock.
- noc_rst  in  1  synchronous, active-high reset.
- id_x  in  ID_X_W  own X coordinate; stamped into the head flit as the source.
- id_y  in  ID_Y_W  own Y coordinate; stamped into the head flit as the source.
- req_valid  in  1  descriptor valid.
- req_ready  out  1  descriptor accepted; high only in IDLE.
- req_dest_x  in  ID_X_W  destination X.
- req_dest_y  in  ID_Y_W  destination Y.
- req_len  in  LEN_W  number of body beats, 0..MAX_LEN.
- pld_valid  in  1  payload beat valid.
- pld_ready  out  1  payload beat consumed.
- pld_data  in  FLIT_W-2  payload beat.
- tx_valid  out  CHANNELS  one-hot flit valid toward the router.
- tx_flit  out  FLIT_W  flit.
- tx_ready  in  CHANNELS  per-VC flit accept.
- tx_vc_ready  in  CHANNELS  per-VC "can start a new packet".
- busy  out  1  state != IDLE.
- len_err  out  1  one-cycle pulse when req_len > MAX_LEN is accepted.
- pkt_count  out  16  packets completed; wraps modulo 2^16.

## Operation
Flit type encoding: 2'b01 head, 2'b00 body, 2'b10 tail, 2'b11 head+tail (used when the packet has 0 body beats).

Head payload layout, from bit 0 upward, with all remaining payload bits zero:
- dest_x, dest_y, src_x (= id_x), src_y (= id_y), len.

FSM states and transitions:
- IDLE
  - req_ready=1.
  - On req_valid: latch dest, len, and the source ID, then go to ARB.
  - If req_len > MAX_LEN: the latched length is clamped to MAX_LEN, and len_err pulses on the following cycle.
- ARB
  - Select the first set bit of tx_vc_ready, scanning from rr_ptr upward with wrap.
  - If any bit is set: register vc, set rr_ptr = (vc+1) mod CHANNELS, go to HEAD.
  - If no bit is set: stay in ARB.
- HEAD
  - Drive tx_valid[vc]=1 and the head flit.
  - On tx_ready[vc]: if len==0, pkt_count++ and go to IDLE; otherwise go to BODY with rem=len.
- BODY
  - tx_valid[vc]=pld_valid and pld_ready=tx_ready[vc].
  - tx_flit = {type, pld_data}, where type = tail if rem==1, else body.
  - Each handshake (pld_valid & tx_ready[vc]) decrements rem.
  - The handshake with rem==1 increments pkt_count and returns to IDLE.

Handshake rules:
- Only tx_valid[vc] may be high; all other tx_valid bits are 0.
- Once asserted in HEAD, tx_valid stays high and tx_flit stays stable until the handshake.
- In BODY, stability is inherited from the pld_* source, which must hold pld_valid and pld_data until pld_ready.
- tx_ready on a VC other than vc is ignored.
- tx_vc_ready is sampled only in ARB. The VC is held for the whole packet (wormhole).
- pld_ready=0 outside BODY.

## Timing
- Reset values: state=IDLE, rr_ptr=0, vc=0, tx_valid=0, tx_flit=0, pld_ready=0, req_ready=0 during reset and 1 the cycle after, busy=0, len_err=0, pkt_count=0.
- Descriptor accepted at edge N → ARB during cycle N+1. With a VC ready in N+1 → head valid in cycle N+2.
- Head accepted at edge M → the first body beat can be handshaken in cycle M+1. Throughput is 1 flit/cycle with continuous ready.
- Back-to-back packets: tail handshake at edge T → req_ready=1 in cycle T+1. Minimum gap between packets is 2 cycles (IDLE, ARB).
- Reset asserted mid-packet: at the next edge everything returns to reset values and the partial packet is abandoned. The router is reset by the same reset.
- pkt_count at 16'hFFFF wraps to 0 on the next completion.

## Test plan
- CHANNELS=2, tx_vc_ready=2'b11, req dest (3,2), len 3, id (1,1), all ready high
  → head on VC0 with type 01 and fields 3,2,1,1,3; then body, body, tail on VC0 on consecutive cycles; pkt_count=1.
- Second identical packet with tx_vc_ready=2'b11 → uses VC1 (rr_ptr=1). A third packet uses VC0.
- len 0 → a single flit of type 11; pld_ready never asserts; pkt_count increments.
- tx_vc_ready=0 for 5 cycles after the request → stays in ARB with tx_valid=0. Set tx_vc_ready=2'b10 → head on VC1 one cycle later.
- len 4, toggle tx_ready[vc] and pld_valid randomly, pulse tx_ready on the other VC → exactly 4 body/tail flits in order; tx_flit stable while stalled; the other-VC ready is ignored.
- req_len=20 → len_err pulses once, the head len field is 16, 16 payload beats are sent. Assert noc_rst after beat 8 → tx_valid=0, busy=0, pkt_count=0 the next cycle.
